// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shift/rotate unit, up to STEP bits per clock under a start/done handshake.
// Supports shr, shra, shl, ror and rol; other modes pass the operand through unchanged.
`default_nettype none

module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int LW = $clog2(WIDTH);
  localparam int RW = LW + 1;
  localparam int EW = AMT_W + RW;

  localparam logic [2:0] M_SHR  = 3'b000;
  localparam logic [2:0] M_SHRA = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       mode_q, mode_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             carry_q, carry_d;

  logic [EW-1:0]    amt_ext;
  logic [RW-1:0]    eff;
  logic [RW-1:0]    s;
  logic [LW-1:0]    shl_idx, shr_idx;
  logic [WIDTH-1:0] shifted;
  logic             shift_c;

  // Zero-extend so the saturation compare works for any AMT_W, even narrower than log2(WIDTH).
  assign amt_ext = {{RW{1'b0}}, amt};

  always_comb begin
    eff = '0;
    case (mode)
      M_SHR, M_SHRA, M_SHL: eff = (amt_ext >= EW'(WIDTH)) ? RW'(WIDTH) : RW'(amt_ext);
      M_ROR, M_ROL:         eff = RW'(amt_ext[LW-1:0]);
      default:              eff = '0;
    endcase
  end

  assign s       = (rem_q > RW'(STEP)) ? RW'(STEP) : rem_q;
  assign shl_idx = LW'(RW'(WIDTH) - s);
  assign shr_idx = LW'(s - RW'(1));

  // Arithmetic shift keeps the MSB, so the working register always carries the latched sign.
  always_comb begin
    shifted = work_q;
    shift_c = carry_q;
    case (mode_q)
      M_SHR: begin
        shifted = work_q >> s;
        shift_c = work_q[shr_idx];
      end
      M_SHRA: begin
        shifted = $signed(work_q) >>> s;
        shift_c = work_q[shr_idx];
      end
      M_SHL: begin
        shifted = work_q << s;
        shift_c = work_q[shl_idx];
      end
      M_ROR: begin
        shifted = (work_q >> s) | (work_q << (RW'(WIDTH) - s));
        shift_c = shifted[WIDTH-1];
      end
      M_ROL: begin
        shifted = (work_q << s) | (work_q >> (RW'(WIDTH) - s));
        shift_c = shifted[0];
      end
      default: begin
        shifted = work_q;
        shift_c = carry_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d  = din;
          mode_d  = mode;
          rem_d   = eff;
          carry_d = 1'b0;
          if (eff == '0) begin
            state_d = S_DONE;
            dout_d  = din;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d  = shifted;
        carry_d = shift_c;
        rem_d   = rem_q - s;
        if (rem_q == s) begin
          state_d = S_DONE;
          dout_d  = shifted;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

  assign dout  = dout_q;
  assign carry = carry_q;
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_unit.sv
// tb_shift_unit: scoreboard bench for shift_unit (WIDTH=32, STEP=4), bit-serial reference model.
`default_nettype none

module tb_shift_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  mode;
  logic [31:0] din;
  logic [31:0] amt;
  logic [31:0] dout;
  logic        carry;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          n;
    int          k;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  shift_unit #(.WIDTH(32), .STEP(4), .AMT_W(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .mode  (mode),
    .din   (din),
    .amt   (amt),
    .dout  (dout),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bit per iteration, independent of the DUT's multi-bit stepping.
  function automatic exp_t model(input logic [2:0] m, input logic [31:0] d, input logic [31:0] a);
    exp_t        r;
    int          eff;
    logic [31:0] w;
    logic        c;
    w = d;
    c = 1'b0;
    case (m)
      3'd0, 3'd1, 3'd2: eff = (a >= 32) ? 32 : int'(a);
      3'd3, 3'd4:       eff = int'(a % 32);
      default:          eff = 0;
    endcase
    for (int i = 0; i < eff; i++) begin
      case (m)
        3'd0: begin c = w[0];  w = {1'b0, w[31:1]}; end
        3'd1: begin c = w[0];  w = {w[31], w[31:1]}; end
        3'd2: begin c = w[31]; w = {w[30:0], 1'b0}; end
        3'd3: begin w = {w[0], w[31:1]}; c = w[31]; end
        default: begin w = {w[30:0], w[31]}; c = w[0]; end
      endcase
    end
    r.d = w;
    r.c = c;
    r.n = (eff + 3) / 4;
    r.k = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!clr) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dout", dout, e.d);
          chk("carry", {31'd0, carry}, {31'd0, e.c});
          chk("latency", 32'(cyc - e.k), 32'(e.n));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.n));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic drive(input logic [2:0] m, input logic [31:0] d, input logic [31:0] a, input bit push);
    exp_t e;
    mode  = m;
    din   = d;
    amt   = a;
    start = 1'b1;
    if (push) begin
      e   = model(m, d, a);
      e.k = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 60; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic op(input logic [2:0] m, input logic [31:0] d, input logic [31:0] a);
    drive(m, d, a, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; mode = '0; din = '0; amt = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    op(3'b001, 32'hFFFF_FFE0, 32'd2);
    op(3'b000, 32'h8000_0000, 32'd31);
    op(3'b011, 32'h0000_0001, 32'd33);
    op(3'b100, 32'h8000_0001, 32'd4);
    op(3'b010, 32'hFFFF_FFFF, 32'd40);
    op(3'b001, 32'h8000_0000, 32'd100);
    op(3'b010, 32'h1234_5678, 32'd0);
    op(3'b111, 32'h1234_5678, 32'd13);
    op(3'b000, 32'hA5A5_0F0F, 32'd32);
    op(3'b011, 32'hC000_0003, 32'd7);
    for (int i = 0; i < 12; i++)
      op(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 70)));

    // Back-to-back: second start lands in the DONE cycle of the first.
    drive(3'b100, 32'h0F00_00F0, 32'd9, 1'b1);
    wait_done();
    drive(3'b000, 32'hF000_0001, 32'd5, 1'b1);
    wait_done();
    drive(3'b010, 32'h0000_0003, 32'd0, 1'b1);
    wait_done();
    @(negedge clk);

    // A start during SHIFT must be ignored.
    drive(3'b000, 32'h8000_0000, 32'd31, 1'b1);
    @(negedge clk);
    mode = 3'b010; din = 32'hDEAD_BEEF; amt = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Asynchronous reset mid-SHIFT aborts with no done pulse.
    drive(3'b000, 32'h8000_0000, 32'd31, 1'b0);
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort_dout", dout, 32'd0);
    chk("abort_carry", {31'd0, carry}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    op(3'b001, 32'hFFFF_FFE0, 32'd2);
    op(3'b100, 32'h8000_0001, 32'd4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
